// File: rtl/sample_accumulator.sv
// Batch sample accumulator feeding the rounding divider: sums up to MAX_COUNT
// unsigned samples and presents a stable, registered sum/count pair per batch.
module sample_accumulator #(
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 13,
    parameter int CNT_W     = 5,
    parameter int MAX_COUNT = 31
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic              i_Sample_Valid,
    input  logic [DATA_W-1:0] i_Sample,
    input  logic              i_Done,
    output logic [SUM_W-1:0]  o_Dividendo,
    output logic [CNT_W-1:0]  o_Divisor,
    output logic              o_Valid,
    output logic              o_Busy,
    output logic              o_Error
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [SUM_W-1:0] SUM_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_COUNT);

    state_t             state_reg, state_next;
    logic [SUM_W-1:0]   sum_reg, sum_next, sum_acc;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_acc;
    logic [SUM_W-1:0]   dividendo_reg, dividendo_next;
    logic [CNT_W-1:0]   divisor_reg, divisor_next;
    logic               valid_reg, valid_next;
    logic               error_reg, error_next;
    logic               busy_reg;
    logic [SUM_W:0]     sum_wide;

    // One extra bit exposes the carry used for saturation.
    assign sum_wide = {1'b0, sum_reg} + (SUM_W+1)'(i_Sample);

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        cnt_next       = cnt_reg;
        dividendo_next = dividendo_reg;
        divisor_next   = divisor_reg;
        valid_next     = 1'b0;
        error_next     = 1'b0;
        sum_acc        = sum_reg;
        cnt_acc        = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (i_Start) begin
                    state_next = ACCUM;
                    sum_next   = '0;
                    cnt_next   = '0;
                end
            end
            ACCUM: begin
                if (i_Start) begin
                    sum_next = '0;
                    cnt_next = '0;
                end else begin
                    if (i_Sample_Valid) begin
                        sum_acc = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
                        cnt_acc = cnt_reg + 1'b1;
                    end
                    sum_next = sum_acc;
                    cnt_next = cnt_acc;
                    // The closing sample is part of the batch, so decide on post-update values.
                    if (i_Done || (i_Sample_Valid && (cnt_acc == CNT_LIMIT))) begin
                        if (cnt_acc == '0) begin
                            state_next = IDLE;
                            error_next = 1'b1;
                        end else begin
                            state_next     = HOLD;
                            dividendo_next = sum_acc;
                            divisor_next   = cnt_acc;
                            valid_next     = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (i_Start) begin
                    state_next = ACCUM;
                    sum_next   = '0;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            dividendo_reg <= '0;
            divisor_reg   <= '0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            cnt_reg       <= cnt_next;
            dividendo_reg <= dividendo_next;
            divisor_reg   <= divisor_next;
            valid_reg     <= valid_next;
            error_reg     <= error_next;
            busy_reg      <= (state_next == ACCUM);
        end
    end

    assign o_Dividendo = dividendo_reg;
    assign o_Divisor   = divisor_reg;
    assign o_Valid     = valid_reg;
    assign o_Busy      = busy_reg;
    assign o_Error     = error_reg;

endmodule

// File: tb/tb_sample_accumulator.sv
// Directed bench for sample_accumulator: a batch-level model (queue of accepted
// samples) is compared against the DUT every cycle, plus literal spot checks.
module tb_sample_accumulator;

    localparam int DATA_W    = 8;
    localparam int SUM_W     = 13;
    localparam int CNT_W     = 5;
    localparam int MAX_COUNT = 31;

    logic              i_Clk = 1'b0;
    logic              i_Rst = 1'b0;
    logic              i_Start = 1'b0;
    logic              i_Sample_Valid = 1'b0;
    logic [DATA_W-1:0] i_Sample = '0;
    logic              i_Done = 1'b0;
    logic [SUM_W-1:0]  o_Dividendo;
    logic [CNT_W-1:0]  o_Divisor;
    logic              o_Valid;
    logic              o_Busy;
    logic              o_Error;

    sample_accumulator #(
        .DATA_W(DATA_W), .SUM_W(SUM_W), .CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start),
        .i_Sample_Valid(i_Sample_Valid), .i_Sample(i_Sample), .i_Done(i_Done),
        .o_Dividendo(o_Dividendo), .o_Divisor(o_Divisor), .o_Valid(o_Valid),
        .o_Busy(o_Busy), .o_Error(o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Batch-level model: 0 idle, 1 collecting, 2 holding a result.
    int m_mode = 0;
    int batch[$];
    int exp_div = 0, exp_cnt = 0, exp_valid = 0, exp_busy = 0, exp_err = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int batch_sum();
        int s = 0;
        foreach (batch[i]) s += batch[i];
        if (s > (1 << SUM_W) - 1) s = (1 << SUM_W) - 1;
        return s;
    endfunction

    task automatic model_edge();
        exp_valid = 0;
        exp_err   = 0;
        if (!i_Rst) begin
            m_mode = 0;
            batch.delete();
            exp_div = 0;
            exp_cnt = 0;
        end else if (m_mode == 0 || m_mode == 2) begin
            if (i_Start) begin
                batch.delete();
                m_mode = 1;
            end
        end else if (i_Start) begin
            batch.delete();
        end else begin
            if (i_Sample_Valid) batch.push_back(int'(i_Sample));
            if (i_Done || batch.size() == MAX_COUNT) begin
                if (batch.size() == 0) begin
                    exp_err = 1;
                    m_mode  = 0;
                end else begin
                    exp_div   = batch_sum();
                    exp_cnt   = batch.size();
                    exp_valid = 1;
                    m_mode    = 2;
                end
            end
        end
        exp_busy = (m_mode == 1) ? 1 : 0;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input bit rst_n, input bit st, input bit sv, input int smp, input bit dn);
        i_Rst          = rst_n;
        i_Start        = st;
        i_Sample_Valid = sv;
        i_Sample       = DATA_W'(smp);
        i_Done         = dn;
        @(posedge i_Clk);
        model_edge();
        #1;
        i_Start        = 1'b0;
        i_Sample_Valid = 1'b0;
        i_Done         = 1'b0;
    endtask

    always @(negedge i_Clk) begin
        if (cmp_en) begin
            check("dividendo", int'(o_Dividendo), exp_div);
            check("divisor",   int'(o_Divisor),   exp_cnt);
            check("valid",     int'(o_Valid),     exp_valid);
            check("busy",      int'(o_Busy),      exp_busy);
            check("error",     int'(o_Error),     exp_err);
        end
    end

    initial begin
        int quotient;
        // Test 1: reset, basic batch
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        check("rst_dividendo", int'(o_Dividendo), 0);
        check("rst_busy", int'(o_Busy), 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 10, 0);
        step(1, 0, 1, 20, 0);
        step(1, 0, 1, 30, 0);
        step(1, 0, 1, 40, 0);
        step(1, 0, 0, 0, 1);
        check("t1_valid", int'(o_Valid), 1);
        check("t1_dividendo", int'(o_Dividendo), 100);
        check("t1_divisor", int'(o_Divisor), 4);
        check("t1_model_div", exp_div, 100);
        quotient = (o_Divisor != 0) ? (int'(o_Dividendo) + int'(o_Divisor) / 2) / int'(o_Divisor) : -1;
        check("t1_quotient", quotient, 25);
        step(1, 0, 1, 77, 1);
        check("t1_hold_valid", int'(o_Valid), 0);
        check("t1_hold_div", int'(o_Dividendo), 100);

        // Test 2: automatic close at MAX_COUNT
        step(1, 1, 0, 0, 0);
        check("t2_keep_prev", int'(o_Divisor), 4);
        for (int i = 0; i < MAX_COUNT; i++) begin
            step(1, 0, 1, 255, 0);
            if (i < MAX_COUNT - 1) check("t2_no_early_valid", int'(o_Valid), 0);
        end
        check("t2_valid", int'(o_Valid), 1);
        check("t2_dividendo", int'(o_Dividendo), 7905);
        check("t2_divisor", int'(o_Divisor), 31);
        step(1, 0, 1, 255, 0);
        check("t2_extra_valid", int'(o_Valid), 0);
        check("t2_extra_div", int'(o_Divisor), 31);

        // Test 3: empty batch
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check("t3_error", int'(o_Error), 1);
        check("t3_valid", int'(o_Valid), 0);
        check("t3_busy", int'(o_Busy), 0);
        check("t3_keep_div", int'(o_Dividendo), 7905);
        step(1, 0, 0, 0, 0);
        check("t3_error_once", int'(o_Error), 0);

        // Test 4: restart mid-batch discards the coincident sample
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 50, 0);
        step(1, 1, 1, 99, 0);
        check("t4_busy", int'(o_Busy), 1);
        step(1, 0, 1, 7, 0);
        step(1, 0, 1, 9, 1);
        check("t4_dividendo", int'(o_Dividendo), 16);
        check("t4_divisor", int'(o_Divisor), 2);

        // Test 5: closing sample included
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 2, 0);
        step(1, 0, 1, 5, 1);
        check("t5_dividendo", int'(o_Dividendo), 8);
        check("t5_divisor", int'(o_Divisor), 3);

        // Test 6: reset in the middle of a batch
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 11, 0);
        step(1, 0, 1, 12, 0);
        step(0, 0, 1, 13, 0);
        check("t6_dividendo", int'(o_Dividendo), 0);
        check("t6_divisor", int'(o_Divisor), 0);
        check("t6_busy", int'(o_Busy), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 20 + i, (i == 3));
            check("t6_no_valid", int'(o_Valid), 0);
        end

        step(1, 0, 0, 0, 0);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
